// File: rtl/cdb_pkg.sv
// cdb_pkg: shared types and widths for the common data bus (CDB).
// A CDB packet is {rob_tag, value}; sources are integer, branch, load/store.
package cdb_pkg;

  localparam int CDB_W     = 38;
  localparam int ROB_TAG_W = 6;
  localparam int DATA_W    = 32;
  localparam int SRC_W     = 2;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [DATA_W-1:0]    value;
  } cdb_pkt_t;

  typedef enum logic [SRC_W-1:0] {
    SRC_INT = 2'd0,
    SRC_BR  = 2'd1,
    SRC_LS  = 2'd2
  } cdb_src_e;

  // Build a packet from its fields
  function automatic cdb_pkt_t pack_pkt(input logic [ROB_TAG_W-1:0] tag,
                                        input logic [DATA_W-1:0]    value);
    cdb_pkt_t p;
    p.rob_tag = tag;
    p.value   = value;
    return p;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: per-source circular completion FIFO.
// Head data is read combinationally so the arbiter can register it in the
// same cycle it grants. A push into a full FIFO is accepted only when the
// head is popped on the same edge; otherwise it is dropped and flagged.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int WIDTH = CDB_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign overflow  = push && full && !do_pop;
  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

  // Occupancy after this edge's push/pop
  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointers and count; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Storage write; contents need no reset since the count gates validity
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one registered CDB among NUM_SRC execution units.
// Each unit feeds its own cdb_src_fifo; a round-robin arbiter pops one
// non-empty head per cycle into the CDB output register.
// Optional macro CDB_BRANCH_PRIORITY_EN: the BRANCH_SRC FIFO wins whenever it
// is non-empty and its grants leave the round-robin pointer untouched.
module cdb_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CDB_W      = 38,
  parameter int BRANCH_SRC = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_SRC-1:0]       req_valid,
  input  logic [NUM_SRC*CDB_W-1:0] req_data,
  output logic [NUM_SRC-1:0]       req_stall,
  output logic                     cdb_valid,
  output logic [CDB_W-1:0]         cdb_data,
  output logic [1:0]               cdb_src,
  output logic                     overflow
);

  import cdb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0] empty_vec;
  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] fifo_ovf;
  logic [NUM_SRC-1:0] pop_vec;
  logic [CNT_W-1:0]   count_arr [NUM_SRC];
  logic [CDB_W-1:0]   head_arr  [NUM_SRC];

  logic [SRC_W-1:0]   last_grant_reg;
  logic               cdb_valid_reg;
  logic [CDB_W-1:0]   cdb_data_reg;
  logic [SRC_W-1:0]   cdb_src_reg;
  logic               overflow_reg;

  logic [SRC_W-1:0]   cand;
  logic               rr_valid;
  logic [SRC_W-1:0]   rr_idx;
  logic               grant_valid;
  logic               grant_is_rr;
  logic [SRC_W-1:0]   grant_idx;
  logic [CDB_W-1:0]   grant_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      cdb_src_fifo #(
        .WIDTH (CDB_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (req_valid[gi] && !flush),
        .pop       (pop_vec[gi]),
        .push_data (req_data[gi*CDB_W +: CDB_W]),
        .head_data (head_arr[gi]),
        .count     (count_arr[gi]),
        .empty     (empty_vec[gi]),
        .overflow  (fifo_ovf[gi])
      );

      assign nonempty[gi]  = !empty_vec[gi];
      // One entry of slack for a unit that samples stall a cycle late
      assign req_stall[gi] = (count_arr[gi] >= CNT_W'(FIFO_DEPTH - 1));
      assign pop_vec[gi]   = grant_valid && !flush && (grant_idx == SRC_W'(gi));
    end
  endgenerate

  // Round-robin search starting just after the last granted source
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_W'((int'(last_grant_reg) + k) % NUM_SRC);
      if (!rr_valid && nonempty[cand]) begin
        rr_valid = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Final grant: optional branch override on top of round-robin
  always_comb begin
    grant_valid = rr_valid;
    grant_idx   = rr_idx;
    grant_is_rr = rr_valid;
`ifdef CDB_BRANCH_PRIORITY_EN
    if (nonempty[BRANCH_SRC]) begin
      grant_valid = 1'b1;
      grant_idx   = SRC_W'(BRANCH_SRC);
      grant_is_rr = 1'b0;
    end
`endif
  end

  // Select the winning FIFO head
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == SRC_W'(i)) grant_data = head_arr[i];
    end
  end

  // CDB output register, round-robin pointer and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid_reg  <= 1'b0;
      cdb_data_reg   <= '0;
      cdb_src_reg    <= '0;
      last_grant_reg <= SRC_W'(NUM_SRC - 1);
      overflow_reg   <= 1'b0;
    end else begin
      if (|fifo_ovf) overflow_reg <= 1'b1;
      if (flush) begin
        cdb_valid_reg <= 1'b0;
      end else begin
        cdb_valid_reg <= grant_valid;
        if (grant_valid) begin
          cdb_data_reg <= grant_data;
          cdb_src_reg  <= grant_idx;
        end
        if (grant_is_rr) last_grant_reg <= grant_idx;
      end
    end
  end

  assign cdb_valid = cdb_valid_reg;
  assign cdb_data  = cdb_data_reg;
  assign cdb_src   = cdb_src_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter.
// Stimulus pushes expected packets into per-source queues plus a queue of
// hand-derived grant order; a negedge monitor pops and compares on cdb_valid.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   req_valid = '0;
  logic [113:0] req_data = '0;
  logic [2:0]   req_stall;
  logic         cdb_valid;
  logic [37:0]  cdb_data;
  logic [1:0]   cdb_src;
  logic         overflow;

  cdb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_stall (req_stall),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [37:0] exp_q [3][$];
  int          src_q [$];
  int          seq_cnt [3] = '{0, 0, 0};
  logic [37:0] mon_exp;
  int          mon_src;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + src_q.size();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one line per broadcast packet
  always @(negedge clk) begin
    if (reset && cdb_valid) begin
      mon_src = int'(cdb_src);
      $display("cdb: src=%0d tag=%0d value=%08h", mon_src, cdb_data[37:32], cdb_data[31:0]);
      if (mon_src > 2 || exp_q[mon_src].size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_packet: got src=%0d data=%0h required no packet", mon_src, cdb_data);
      end else begin
        mon_exp = exp_q[mon_src].pop_front();
        check("cdb_data", 64'(cdb_data), 64'(mon_exp));
      end
      if (src_q.size() > 0) begin
        check("grant_order", 64'(cdb_src), 64'(src_q.pop_front()));
      end
    end
  end

  // One edge of stimulus: push mask, accepted mask, expected stall/overflow after the edge
  task automatic drive_row(input string name, input logic [2:0] push, input logic [2:0] acc,
                           input logic [2:0] stall_e, input logic ovf_e);
    logic [37:0] pkt [3];
    for (int s = 0; s < 3; s++) begin
      pkt[s] = pack_pkt(6'((s * 20 + seq_cnt[s]) % 64), (32'(s) << 28) | 32'(seq_cnt[s]));
      if (push[s]) begin
        req_data[s*38 +: 38] = pkt[s];
        seq_cnt[s]++;
      end
    end
    req_valid = push;
    step();
    req_valid = '0;
    for (int s = 0; s < 3; s++) begin
      if (acc[s]) exp_q[s].push_back(pkt[s]);
    end
    check({name, "_stall"}, 64'(req_stall), 64'(stall_e));
    check({name, "_ovf"}, 64'(overflow), 64'(ovf_e));
  endtask

  task automatic drain(input string name);
    req_valid = '0;
    repeat (25) step();
    check({name, "_leftover"}, 64'(pending()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_valid", 64'(cdb_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_stall", 64'(req_stall), 64'd0);
    for (int s = 0; s < 3; s++) exp_q[s].delete();
    src_q.delete();
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(cdb_valid), 64'd0);
    check("reset_data", 64'(cdb_data), 64'd0);
    check("reset_src", 64'(cdb_src), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);
    check("reset_stall", 64'(req_stall), 64'd0);
    reset = 1'b1;

    // Single push: two-edge latency, one-cycle valid
    req_data[37:0] = pack_pkt(6'd5, 32'h1234);
    req_valid = 3'b001;
    step();
    req_valid = '0;
    exp_q[0].push_back({6'd5, 32'h0000_1234});
    src_q.push_back(0);
    check("single_lat1", 64'(cdb_valid), 64'd0);
    step();
    check("single_lat2", 64'(cdb_valid), 64'd1);
    step();
    check("single_after", 64'(cdb_valid), 64'd0);
    drain("single");
    do_reset();

    // Fairness: all sources push, stall respected
    for (int i = 0; i < 19; i++) src_q.push_back(i % 3);
    drive_row("fair1", 3'b111, 3'b111, 3'b000, 1'b0);
    drive_row("fair2", 3'b111, 3'b111, 3'b000, 1'b0);
    drive_row("fair3", 3'b111, 3'b111, 3'b100, 1'b0);
    drive_row("fair4", 3'b011, 3'b011, 3'b011, 1'b0);
    for (int r = 0; r < 8; r++) begin
      case (r % 3)
        0: drive_row("fair_p0", 3'b100, 3'b100, 3'b110, 1'b0);
        1: drive_row("fair_p1", 3'b001, 3'b001, 3'b101, 1'b0);
        default: drive_row("fair_p2", 3'b010, 3'b010, 3'b011, 1'b0);
      endcase
    end
    drain("fair");
    do_reset();

    // Backpressure: src2 pushes 3 while src0/src1 saturate
    src_q = {0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 0, 1, 0, 1};
    drive_row("bp1", 3'b111, 3'b111, 3'b000, 1'b0);
    drive_row("bp2", 3'b111, 3'b111, 3'b000, 1'b0);
    drive_row("bp3", 3'b111, 3'b111, 3'b100, 1'b0);
    drive_row("bp4", 3'b011, 3'b011, 3'b011, 1'b0);
    drive_row("bp5", 3'b000, 3'b000, 3'b010, 1'b0);
    drive_row("bp6", 3'b001, 3'b001, 3'b001, 1'b0);
    drive_row("bp7", 3'b010, 3'b010, 3'b011, 1'b0);
    drive_row("bp8", 3'b000, 3'b000, 3'b010, 1'b0);
    drive_row("bp9", 3'b001, 3'b001, 3'b001, 1'b0);
    drive_row("bp10", 3'b010, 3'b010, 3'b011, 1'b0);
    drain("bp");
    do_reset();

    // Priority stimulus: src0 and src1 push every cycle
`ifdef CDB_BRANCH_PRIORITY_EN
    src_q = {1, 1, 1, 1, 0, 0, 0, 0};
    drive_row("prio1", 3'b011, 3'b011, 3'b000, 1'b0);
    drive_row("prio2", 3'b011, 3'b011, 3'b000, 1'b0);
    drive_row("prio3", 3'b011, 3'b011, 3'b001, 1'b0);
    drive_row("prio4", 3'b011, 3'b011, 3'b001, 1'b0);
`else
    src_q = {0, 1, 0, 1, 0, 1, 0, 1};
    drive_row("prio1", 3'b011, 3'b011, 3'b000, 1'b0);
    drive_row("prio2", 3'b011, 3'b011, 3'b000, 1'b0);
    drive_row("prio3", 3'b011, 3'b011, 3'b000, 1'b0);
    drive_row("prio4", 3'b011, 3'b011, 3'b010, 1'b0);
`endif
    drain("prio");
    do_reset();

    // Overflow: src1 ignores stall; its 7th push hits a full FIFO
    src_q = {0, 1, 2, 0, 1, 2};
    drive_row("ovf1", 3'b111, 3'b111, 3'b000, 1'b0);
    drive_row("ovf2", 3'b111, 3'b111, 3'b000, 1'b0);
    drive_row("ovf3", 3'b111, 3'b111, 3'b100, 1'b0);
    drive_row("ovf4", 3'b011, 3'b011, 3'b011, 1'b0);
    drive_row("ovf5", 3'b110, 3'b110, 3'b110, 1'b0);
    drive_row("ovf6", 3'b011, 3'b011, 3'b111, 1'b0);
    drive_row("ovf7", 3'b010, 3'b000, 3'b011, 1'b1);

    // Flush with everything still queued; same-cycle pushes are discarded
    req_valid = 3'b111;
    flush = 1'b1;
    step();
    flush = 1'b0;
    req_valid = '0;
    check("flush_valid", 64'(cdb_valid), 64'd0);
    check("flush_stall", 64'(req_stall), 64'd0);
    check("flush_ovf_kept", 64'(overflow), 64'd1);
    check("flush_prior_seen", 64'(src_q.size()), 64'd0);
    for (int s = 0; s < 3; s++) exp_q[s].delete();

    // Fresh pushes after flush; last_grant=2 kept so src0 precedes src2
    src_q = {0, 2};
    drive_row("fresh", 3'b101, 3'b101, 3'b000, 1'b1);
    check("fresh_lat1", 64'(cdb_valid), 64'd0);
    step();
    check("fresh_lat2", 64'(cdb_valid), 64'd1);
    drain("fresh");

    // Reset mid-operation discards queued packets and clears overflow
    drive_row("midrst1", 3'b011, 3'b011, 3'b000, 1'b1);
    drive_row("midrst2", 3'b011, 3'b011, 3'b000, 1'b1);
    #1;
    do_reset();
    drain("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
